// File: rtl/neopix_tx.sv
// neopix_tx: byte FIFO feeding a WS2812 single-wire serialiser.
// Bytes are shifted out MSB-first with fixed high-time pulses per bit.
// When the queue runs dry after a byte, a latch low period is emitted.
module neopix_tx #(
  parameter int DEPTH_LOG2 = 4,
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int TBIT       = 62,
  parameter int TRES       = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       dout,
  output logic       busy,
  output logic       overflow
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int CNT_MAX = (TRES > TBIT) ? TRES : TBIT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int LW      = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] C_TBIT_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] C_TRES_LAST = CW'(TRES - 1);
  localparam logic [CW-1:0] C_T0H       = CW'(T0H);
  localparam logic [CW-1:0] C_T1H       = CW'(T1H);
  localparam logic [CW-1:0] C_CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);
  localparam logic [LW-1:0] C_LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] C_LVL_ZERO  = LW'(0);
  localparam logic [LW-1:0] C_LVL_ONE   = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ZERO = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // High time of one bit period for the given data bit value.
  function automatic logic [CW-1:0] high_time(input logic b);
    return b ? C_T1H : C_T0H;
  endfunction

  // FIFO storage and bookkeeping
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_overflow;

  // Serialiser state
  state_t                r_state;
  logic [7:0]            r_shreg;
  logic [2:0]            r_bit;
  logic [CW-1:0]         r_cnt;
  logic                  r_dout;
  logic                  r_busy;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [7:0]            w_head;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_bit_end;
  logic [LW-1:0]         w_level_nxt;

  assign w_full    = (r_level == C_LVL_FULL);
  assign w_empty   = (r_level == C_LVL_ZERO);
  assign w_push    = din_valid & ~w_full;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_cnt_inc = r_cnt + C_CNT_ONE;
  assign w_bit_end = (r_cnt == C_TBIT_LAST);

  // Pop decision: IDLE fetches a new byte, SEND chains the next byte at the end of bit 7.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = ~w_empty;
      ST_SEND: begin
        if (w_bit_end && (r_bit == 3'd7)) begin
          w_pop = ~w_empty;
        end else begin
          w_pop = 1'b0;
        end
      end
      default: w_pop = 1'b0;
    endcase
  end

  // Next FIFO level; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + C_LVL_ONE;
      2'b01:   w_level_nxt = r_level - C_LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // FIFO data array write; contents are invalidated by the pointer reset alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // FIFO pointers, level and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= C_PTR_ZERO;
      r_rd_ptr   <= C_PTR_ZERO;
      r_level    <= C_LVL_ZERO;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_level <= w_level_nxt;
      if (din_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Serialiser FSM; dout and busy are registered from the values the state takes next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shreg <= 8'h00;
      r_bit   <= 3'd0;
      r_cnt   <= C_CNT_ZERO;
      r_dout  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_shreg <= w_head;
            r_bit   <= 3'd0;
            r_cnt   <= C_CNT_ZERO;
            r_state <= ST_SEND;
            r_dout  <= (high_time(w_head[7]) != C_CNT_ZERO);
            r_busy  <= 1'b1;
          end else begin
            r_dout  <= 1'b0;
            r_busy  <= w_push;
          end
        end
        ST_SEND: begin
          r_busy <= 1'b1;
          if (w_bit_end) begin
            r_cnt <= C_CNT_ZERO;
            if (r_bit != 3'd7) begin
              r_shreg <= {r_shreg[6:0], 1'b0};
              r_bit   <= r_bit + 3'd1;
              r_dout  <= (high_time(r_shreg[6]) != C_CNT_ZERO);
            end else if (!w_empty) begin
              r_shreg <= w_head;
              r_bit   <= 3'd0;
              r_dout  <= (high_time(w_head[7]) != C_CNT_ZERO);
            end else begin
              r_state <= ST_LATCH;
              r_dout  <= 1'b0;
            end
          end else begin
            r_cnt  <= w_cnt_inc;
            r_dout <= (w_cnt_inc < high_time(r_shreg[7]));
          end
        end
        ST_LATCH: begin
          r_dout <= 1'b0;
          if (r_cnt == C_TRES_LAST) begin
            r_cnt   <= C_CNT_ZERO;
            r_state <= ST_IDLE;
            r_busy  <= (w_level_nxt != C_LVL_ZERO);
          end else begin
            r_cnt   <= w_cnt_inc;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= C_CNT_ZERO;
          r_dout  <= 1'b0;
          r_busy  <= w_push;
        end
      endcase
    end
  end

  assign dout     = r_dout;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule
